pisa_sequencer: RTL and testbench
=================================

# pisa_sequencer

Multi-cycle control sequencer for the PISA core. It steps each instruction through fetch, decode, execute, optional memory access and writeback. It drives PC, instruction-register, register-file and memory-port enables from the decoded `control_signal_t` and the `CU`'s ALU flags. It sits between the `CU` decoder and the shared single-port memory. Instruction fetch and `loda`/`stoa` data accesses share that memory through one request/acknowledge handshake.

## Interface
- `PC_W`, default 16: program counter / address width (informational; the sequencer only drives selects).
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ctrl`  in  `control_signal_t`  decoded control word from `CU`, valid in DECODE onward.
- `alu_zero`  in  1  ALU result == 0.
- `alu_neg`  in  1  ALU result MSB.
- `mem_ack`  in  1  memory accepted/completed the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write (`stoa`), 0 = read.
- `mem_addr_sel`  out  1  0 = PC (fetch), 1 = data address.
- `ir_we`  out  1  load instruction register from memory read data.
- `pc_we`  out  1  update PC.
- `pc_sel`  out  2  PC source: 0 = PC+1, 1 = rdest, 2 = PC+immediate, 3 = absolute address (encoding equals `jmp_src`).
- `reg_we`  out  1  register-file write enable.
- `state`  out  `seq_state_t`  current state, for debug.
- `halted`  out  1  core stopped.
- `retired`  out  `CNT_W`  count of completed instructions.

## Operation
- States:
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr_sel`=0. On `mem_ack`, pulse `ir_we` and go to DECODE. Otherwise stay.
  - DECODE: if `ctrl.halt`, go to HALT. Otherwise go to EXECUTE.
  - EXECUTE: the ALU result settles and the flags are sampled into the branch decision.
    - Taken jump: `pc_we`=1, `pc_sel`=`ctrl.jmp_src`, increment `retired`, go to FETCH.
    - Not taken, and `write_memory_src`≠0 or `write_register_src`=MEMORY: go to MEMORY.
    - Otherwise: go to WRITEBACK.
  - MEMORY: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(`write_memory_src`≠0). On `mem_ack`, go to WRITEBACK.
  - WRITEBACK: `reg_we`=(`write_register_src`≠0), `pc_we`=1, `pc_sel`=0, increment `retired`, go to FETCH.
  - HALT: terminal until reset. `halted`=1. No enables asserted.
- Branch decision, taken iff `jmp_src`≠0 and the condition holds:
  - `jump_condition` 000: always.
  - 010: `alu_zero`.
  - 011: !`alu_zero`.
  - 100: `alu_neg`.
  - 101: !`alu_neg`.
  - Any other encoding: never taken.
- A conditional jump that is not taken behaves as a plain instruction: WRITEBACK with `reg_we`=0.
- `retired` wraps modulo 2^`CNT_W`. `hlt` and invalid opcodes do not retire.
- All enables are Moore outputs of state, except these Mealy pulses, combinational on `mem_ack` in FETCH:
  - `ir_we`.
  - The FETCH→DECODE transition.

## Timing
- Reset value of every output:
  - `state`=FETCH.
  - `mem_req`=1 after release; 0 while `rst_n`=0.
  - All other enables 0.
  - `halted`=0.
  - `retired`=0.
- Assertion of `rst_n` takes effect immediately (asynchronous), including mid-handshake. `mem_req` drops combinationally and memory must tolerate the abandoned transaction. Deassertion is synchronised externally.
- Handshake:
  - `mem_req`, `mem_we` and `mem_addr_sel` stay stable from assertion until the cycle `mem_ack`=1.
  - Exactly one transfer per ack.
  - `mem_ack` while `mem_req`=0 is ignored.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU/cpy: 4 cycles.
  - `loda`/`stoa`: 5 cycles.
  - Taken jump: 3 cycles.
  - `hlt`: 2 cycles to `halted`.
- Each memory wait cycle adds one cycle.

## Structure
- Shared package `pisa_pkg` holds:
  - `control_signal_t`.
  - The `write_register_src`, `write_memory_src`, `jmp_src` and `jump_condition` enums (moved out of `CU`).
  - New `seq_state_t` (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT).
- One combinational sub-module, `pisa_branch_eval` (`jmp_src`, `jump_condition`, `alu_zero`, `alu_neg` → `taken`), reused later by a pipelined front end.

## Test plan
- Reset release, `ctrl` = add (WR_RDEST), `mem_ack` tied 1 → states FETCH, DECODE, EXECUTE, WRITEBACK, FETCH; `reg_we` and `pc_we`(`pc_sel`=0) high only in WRITEBACK; `retired`=1 after 4 cycles.
- `loda` with `mem_ack` low for 3 MEMORY cycles → `mem_req`=1, `mem_addr_sel`=1, `mem_we`=0 held stable 4 cycles; then WRITEBACK with `reg_we`=1; total 8 cycles.
- `jer` (`jmp_src`=2, cond=010) with `alu_zero`=1 → `pc_we`=1, `pc_sel`=2 in EXECUTE, back to FETCH, no `reg_we`. With `alu_zero`=0 → WRITEBACK, `pc_sel`=0, `reg_we`=0.
- `ctrl.halt`=1 (opcode 0x03 or an invalid opcode) → HALT after DECODE; `halted`=1 held for 100 cycles with any `mem_ack`; `retired` unchanged.
- `rst_n` pulled low mid-MEMORY `stoa` (ack pending) → outputs return to reset values in the same cycle; after release, FETCH with `retired`=0.
- Preload `retired`=2^32−1 via forced counter, retire one instruction → `retired` wraps to 0.

Source files
------------

// File: rtl/pisa_pkg.sv
// Shared PISA core types: decoded control word, its field encodings and the
// multi-cycle sequencer state set. Used by the CU decoder and the sequencer.
package pisa_pkg;

  // Register-file write data source; WR_NONE means no register write.
  typedef enum logic [2:0] {
    WR_NONE      = 3'd0,
    WR_RDEST     = 3'd1,
    WR_MEMORY    = 3'd2,
    WR_IMMEDIATE = 3'd3,
    WR_RSRC      = 3'd4
  } write_register_src_t;

  // Memory write data source; WM_NONE means no memory write.
  typedef enum logic [1:0] {
    WM_NONE  = 2'd0,
    WM_RSRC  = 2'd1,
    WM_RDEST = 2'd2
  } write_memory_src_t;

  // Jump target source; the encoding doubles as the PC source select.
  typedef enum logic [1:0] {
    JS_NONE  = 2'd0,
    JS_RDEST = 2'd1,
    JS_REL   = 2'd2,
    JS_ABS   = 2'd3
  } jmp_src_t;

  // Jump condition; unlisted encodings are never taken.
  typedef enum logic [2:0] {
    JC_ALWAYS = 3'b000,
    JC_ZERO   = 3'b010,
    JC_NZERO  = 3'b011,
    JC_NEG    = 3'b100,
    JC_NNEG   = 3'b101
  } jump_condition_t;

  // Decoded control word produced by the CU.
  typedef struct packed {
    logic                halt;
    write_register_src_t write_register_src;
    write_memory_src_t   write_memory_src;
    jmp_src_t            jmp_src;
    jump_condition_t     jump_condition;
  } control_signal_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } seq_state_t;

  localparam logic [1:0] PC_SEL_INC = 2'd0;

  // True when a non-jumping instruction needs a data access (loda/stoa).
  function automatic logic needs_memory(input control_signal_t c);
    return (c.write_memory_src != WM_NONE) || (c.write_register_src == WR_MEMORY);
  endfunction

endpackage

// File: rtl/pisa_branch_eval.sv
// Branch decision: combines jump source, jump condition and ALU flags into a
// single taken bit. Purely combinational so a pipelined front end can reuse it.
module pisa_branch_eval
  import pisa_pkg::*;
(
  input  jmp_src_t        jmp_src,
  input  jump_condition_t jump_condition,
  input  logic            alu_zero,
  input  logic            alu_neg,
  output logic            taken
);

  logic cond;

  // Evaluate the condition against the flags; unknown encodings never hold.
  always_comb begin
    cond = 1'b0;
    case (jump_condition)
      JC_ALWAYS: cond = 1'b1;
      JC_ZERO:   cond = alu_zero;
      JC_NZERO:  cond = !alu_zero;
      JC_NEG:    cond = alu_neg;
      JC_NNEG:   cond = !alu_neg;
      default:   cond = 1'b0;
    endcase
  end

  assign taken = (jmp_src != JS_NONE) && cond;

endmodule

// File: rtl/pisa_sequencer.sv
// Multi-cycle control sequencer for the PISA core. Steps each instruction
// through fetch, decode, execute, optional memory access and writeback, and
// arbitrates the shared single-port memory between fetch and loda/stoa.
module pisa_sequencer
  import pisa_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  control_signal_t  ctrl,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output seq_state_t       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic             taken;
  logic             retire;

  pisa_branch_eval u_branch_eval (
    .jmp_src        (ctrl.jmp_src),
    .jump_condition (ctrl.jump_condition),
    .alu_zero       (alu_zero),
    .alu_neg        (alu_neg),
    .taken          (taken)
  );

  // State and retired counter; asynchronous reset abandons any pending handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      retired_reg <= retired_next;
    end
  end

  // Next state and enables: Moore per state, except ir_we and FETCH exit on mem_ack.
  always_comb begin
    state_next   = state_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_INC;
    reg_we       = 1'b0;
    halted       = 1'b0;
    retire       = 1'b0;
    case (state_reg)
      FETCH: begin
        // Request is held off while reset is asserted, so an ack then is ignored.
        mem_req = rst_n;
        if (rst_n && mem_ack) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = ctrl.halt ? HALT : EXECUTE;
      end
      EXECUTE: begin
        if (taken) begin
          pc_we      = 1'b1;
          pc_sel     = ctrl.jmp_src;
          retire     = 1'b1;
          state_next = FETCH;
        end else if (needs_memory(ctrl)) begin
          state_next = MEMORY;
        end else begin
          state_next = WRITEBACK;
        end
      end
      MEMORY: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (ctrl.write_memory_src != WM_NONE);
        if (mem_ack) begin
          state_next = WRITEBACK;
        end
      end
      WRITEBACK: begin
        reg_we     = (ctrl.write_register_src != WR_NONE);
        pc_we      = 1'b1;
        pc_sel     = PC_SEL_INC;
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
    retired_next = retire ? retired_reg + CNT_W'(1) : retired_reg;
  end

  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_pisa_sequencer.sv
// Self-checking bench for pisa_sequencer. Each instruction is scripted as a
// timeline of phases derived from the latency rules; a compare process checks
// every cycle against the scripted expectation.
module tb_pisa_sequencer;
  import pisa_pkg::*;

  localparam int CW = $bits(control_signal_t);

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  control_signal_t ctrl = '0;
  logic            alu_zero = 1'b0;
  logic            alu_neg = 1'b0;
  logic            mem_ack = 1'b0;
  logic            mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, halted;
  logic [1:0]      pc_sel;
  seq_state_t      state;
  logic [31:0]     retired;

  typedef struct packed {
    seq_state_t st;
    logic       req;
    logic       we;
    logic       asel;
    logic       ir;
    logic       pcwe;
    logic [1:0] pcsel;
    logic       regwe;
    logic       halted;
  } exp_t;

  exp_t        e_cur = '0;
  logic        exp_valid = 1'b0;
  logic [31:0] m_retired = '0;
  logic        retire_pending = 1'b0;
  int          n_err = 0;
  int          n_checks = 0;
  int          n_instr = 0;

  always #5 clk = ~clk;

  pisa_sequencer #(.PC_W(16), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl         (ctrl),
    .alu_zero     (alu_zero),
    .alu_neg      (alu_neg),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .state        (state),
    .halted       (halted),
    .retired      (retired)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, want, $time);
    end
  endfunction

  // Branch rule straight from the condition table.
  function automatic logic model_taken(input logic [1:0] js, input logic [2:0] jc,
                                       input logic z, input logic n);
    logic cond;
    cond = (jc == 3'b000) || (jc == 3'b010 && z) || (jc == 3'b011 && !z) ||
           (jc == 3'b100 && n) || (jc == 3'b101 && !n);
    return (js != 2'd0) && cond;
  endfunction

  function automatic exp_t idle(input seq_state_t st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic control_signal_t rand_ctrl();
    logic [31:0] r;
    r = $urandom;
    return r[CW-1:0];
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Per-cycle comparison against the scripted expectation.
  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      check("state", 32'(state), 32'(e_cur.st));
      check("mem_req", 32'(mem_req), 32'(e_cur.req));
      check("mem_we", 32'(mem_we), 32'(e_cur.we));
      check("mem_addr_sel", 32'(mem_addr_sel), 32'(e_cur.asel));
      check("ir_we", 32'(ir_we), 32'(e_cur.ir));
      check("pc_we", 32'(pc_we), 32'(e_cur.pcwe));
      check("pc_sel", 32'(pc_sel), 32'(e_cur.pcsel));
      check("reg_we", 32'(reg_we), 32'(e_cur.regwe));
      check("halted", 32'(halted), 32'(e_cur.halted));
      check("retired", retired, m_retired);
    end
  end

  task automatic cycle(input exp_t e, input logic ack, input control_signal_t c,
                       input logic z, input logic n, input logic retire);
    @(negedge clk);
    if (retire_pending) begin
      m_retired = m_retired + 32'd1;
      retire_pending = 1'b0;
    end
    mem_ack = ack;
    ctrl = c;
    alu_zero = z;
    alu_neg = n;
    e_cur = e;
    exp_valid = 1'b1;
    retire_pending = retire;
  endtask

  // Assert reset mid-cycle, check outputs at once, release on the next falling edge.
  task automatic assert_reset_now();
    exp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'(FETCH));
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr_sel", 32'(mem_addr_sel), 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    check("rst_pc_sel", 32'(pc_sel), 32'd0);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", retired, 32'd0);
    mem_ack = 1'b1;
    #1;
    check("rst_ir_we_ack_ignored", 32'(ir_we), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    m_retired = '0;
    retire_pending = 1'b0;
    #1;
    check("rel_state", 32'(state), 32'(FETCH));
    check("rel_mem_req", 32'(mem_req), 32'd1);
    check("rel_retired", retired, 32'd0);
    $display("reset applied and released at t=%0t", $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    exp_valid = 1'b0;
    #3;
    assert_reset_now();
  endtask

  task automatic pin_retired(input string name, input logic [31:0] want);
    @(posedge clk);
    #1;
    check(name, retired, want);
  endtask

  task automatic run_instr(input control_signal_t c, input logic z, input logic n,
                           input int fw, input int mw, input int hc, input logic abort);
    exp_t e;
    logic taken;
    logic need_mem;
    taken = model_taken(c.jmp_src, c.jump_condition, z, n);
    need_mem = !taken && ((c.write_memory_src != WM_NONE) ||
                          (c.write_register_src == WR_MEMORY));
    n_instr++;
    $display("instr %0d: ctrl=%03h zero=%b neg=%b fetch_wait=%0d mem_wait=%0d taken=%b mem=%b halt=%b abort=%b",
             n_instr, c, z, n, fw, mw, taken, need_mem, c.halt, abort && need_mem && mw > 0);
    e = idle(FETCH);
    e.req = 1'b1;
    for (int i = 0; i < fw; i++) cycle(e, 1'b0, rand_ctrl(), rbit(), rbit(), 1'b0);
    e.ir = 1'b1;
    cycle(e, 1'b1, rand_ctrl(), rbit(), rbit(), 1'b0);
    cycle(idle(DECODE), rbit(), c, rbit(), rbit(), 1'b0);
    if (c.halt) begin
      e = idle(HALT);
      e.halted = 1'b1;
      for (int i = 0; i < hc; i++) cycle(e, rbit(), c, rbit(), rbit(), 1'b0);
      return;
    end
    e = idle(EXECUTE);
    if (taken) begin
      e.pcwe = 1'b1;
      e.pcsel = c.jmp_src;
    end
    cycle(e, rbit(), c, z, n, taken);
    if (taken) return;
    if (need_mem) begin
      e = idle(MEMORY);
      e.req = 1'b1;
      e.asel = 1'b1;
      e.we = (c.write_memory_src != WM_NONE);
      for (int i = 0; i < mw; i++) cycle(e, 1'b0, c, rbit(), rbit(), 1'b0);
      if (abort && mw > 0) begin
        #3;
        exp_valid = 1'b0;
        assert_reset_now();
        return;
      end
      cycle(e, 1'b1, c, rbit(), rbit(), 1'b0);
    end
    e = idle(WRITEBACK);
    e.regwe = (c.write_register_src != WR_NONE);
    e.pcwe = 1'b1;
    cycle(e, rbit(), c, rbit(), rbit(), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    control_signal_t c;
    exp_t e;
    logic abort;

    do_reset();

    // add: ALU result into rdest, zero-wait memory.
    c = '0;
    c.write_register_src = WR_RDEST;
    run_instr(c, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    pin_retired("add_retired", 32'd1);

    // loda with three memory wait cycles.
    c = '0;
    c.write_register_src = WR_MEMORY;
    run_instr(c, 1'b0, 1'b0, 0, 3, 0, 1'b0);
    pin_retired("loda_retired", 32'd2);

    // jer taken and not taken.
    c = '0;
    c.jmp_src = JS_REL;
    c.jump_condition = JC_ZERO;
    run_instr(c, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    pin_retired("jer_taken_retired", 32'd3);
    run_instr(c, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    pin_retired("jer_not_taken_retired", 32'd4);

    // stoa with fetch and memory waits.
    c = '0;
    c.write_memory_src = WM_RSRC;
    run_instr(c, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    pin_retired("stoa_retired", 32'd5);

    // hlt: terminal for 100 cycles, counter untouched.
    c = '0;
    c.halt = 1'b1;
    run_instr(c, 1'b0, 1'b0, 1, 0, 100, 1'b0);
    #1;
    check("halt_held", 32'(halted), 32'd1);
    check("halt_retired", retired, 32'd5);
    do_reset();

    // stoa aborted by reset while ack is pending.
    c = '0;
    c.write_memory_src = WM_RDEST;
    run_instr(c, 1'b0, 1'b0, 0, 2, 0, 1'b1);

    // Counter wrap: preload all-ones, then retire.
    force dut.retired_reg = 32'hFFFF_FFFF;
    m_retired = 32'hFFFF_FFFF;
    e = idle(FETCH);
    e.req = 1'b1;
    cycle(e, 1'b0, rand_ctrl(), 1'b0, 1'b0, 1'b0);
    cycle(e, 1'b0, rand_ctrl(), 1'b0, 1'b0, 1'b0);
    release dut.retired_reg;
    c = '0;
    c.write_register_src = WR_RSRC;
    run_instr(c, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    pin_retired("wrap_retired", 32'd0);
    run_instr(c, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    pin_retired("after_wrap_retired", 32'd1);

    // Randomized instruction stream.
    for (int k = 0; k < 300; k++) begin
      c = rand_ctrl();
      c.halt = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 24) == 0);
      run_instr(c, rbit(), rbit(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(2, 6)), abort);
      if (c.halt) do_reset();
    end

    @(negedge clk);
    exp_valid = 1'b0;
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
